// File: rtl/ddr_cmd_pkg.sv
// Command encodings and latency lookup shared across the DDR5 command path.
// Only the four data commands carry a latency; everything else maps to zero.
package ddr_cmd_pkg;

   typedef enum logic [3:0] {
      CMD_RD   = 4'b0100,
      CMD_WRA  = 4'b0101,
      CMD_WR   = 4'b0111,
      CMD_RDA  = 4'b1100,
      CMD_ACTC = 4'b0011
   } cmd_e;

   function automatic logic is_data_cmd(input logic [3:0] c);
      return (c == CMD_RD) || (c == CMD_RDA) || (c == CMD_WR) || (c == CMD_WRA);
   endfunction

   function automatic logic is_write_cmd(input logic [3:0] c);
      return (c == CMD_WR) || (c == CMD_WRA);
   endfunction

   function automatic int cmd_latency(input logic [3:0] c, input int cl, input int cla,
                                      input int wr_offset);
      case (c)
         CMD_RD:  return cl;
         CMD_RDA: return cla;
         CMD_WR:  return cl - wr_offset;
         CMD_WRA: return cla - wr_offset;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/data_slot_alloc_if.sv
// Scheduler-to-allocator bundle: command/congestion in, grant pulses and DQ strobes out.
interface data_slot_alloc_if #(
   parameter int SLOTS    = 16,
   parameter int MAX_SLIP = 4
);
   localparam int SLIP_W = $clog2(MAX_SLIP + 1);

   logic [3:0]        cmd;
   logic [SLOTS-1:0]  cong;
   logic              alloc_ok;
   logic              alloc_rej;
   logic [SLIP_W-1:0] alloc_slip;
   logic [SLOTS-1:0]  mux_sel;
   logic              dq_active;
   logic              dq_write;

   modport master (
      output cmd, cong,
      input  alloc_ok, alloc_rej, alloc_slip, mux_sel, dq_active, dq_write
   );

   modport slave (
      input  cmd, cong,
      output alloc_ok, alloc_rej, alloc_slip, mux_sel, dq_active, dq_write
   );
endinterface

// File: rtl/data_slot_alloc_first_fit.sv
// Combinational first-fit search: lowest slip s whose BURST-wide window at base+s
// has no busy bit.
module slot_first_fit #(
   parameter int SLOTS    = 16,
   parameter int BURST    = 2,
   parameter int MAX_SLIP = 4,
   localparam int IDX_W   = $clog2(SLOTS),
   localparam int SLIP_W  = $clog2(MAX_SLIP + 1)
) (
   input  logic [SLOTS-1:0]  busy,
   input  logic [IDX_W-1:0]  base,
   output logic              found,
   output logic [SLIP_W-1:0] slip
);
   localparam logic [SLOTS-1:0] WIN0 = {{(SLOTS-BURST){1'b0}}, {BURST{1'b1}}};

   logic [MAX_SLIP:0] free_win;

   generate
      for (genvar gi = 0; gi <= MAX_SLIP; gi++) begin : g_win
         assign free_win[gi] = ~|(busy & (WIN0 << (int'(base) + gi)));
      end
   endgenerate

   // Scan from the top so the lowest free window is the last one written.
   always_comb begin
      found = 1'b0;
      slip  = '0;
      for (int i = MAX_SLIP; i >= 0; i--) begin
         if (free_win[i]) begin
            found = 1'b1;
            slip  = SLIP_W'(i);
         end
      end
   end
endmodule

// File: rtl/data_slot_alloc.sv
// DQ bus slot allocator: shifting occupancy/direction timeline, first-fit window
// reservation per data command, registered grant pulses and DQ strobes.
module data_slot_alloc
   import ddr_cmd_pkg::*;
#(
   parameter int CL        = 4,
   parameter int CLA       = 6,
   parameter int WR_OFFSET = 2,
   parameter int SLOTS     = 16,
   parameter int BURST     = 2,
   parameter int MAX_SLIP  = 4
) (
   input logic              clk,
   input logic              rst,
   data_slot_alloc_if.slave bus
);
   localparam int IDX_W  = $clog2(SLOTS);
   localparam int SLIP_W = $clog2(MAX_SLIP + 1);
   localparam logic [SLOTS-1:0] WIN0 = {{(SLOTS-BURST){1'b0}}, {BURST{1'b1}}};
   localparam logic [SLOTS-1:0] BIT0 = {{(SLOTS-1){1'b0}}, 1'b1};

   logic [SLOTS-1:0]  occ_q, occ_d;
   logic [SLOTS-1:0]  dir_q, dir_d;
   logic              alloc_ok_q, alloc_ok_d;
   logic              alloc_rej_q, alloc_rej_d;
   logic [SLIP_W-1:0] alloc_slip_q, alloc_slip_d;
   logic [SLOTS-1:0]  mux_sel_q, mux_sel_d;

   logic              data_cmd;
   logic              write_cmd;
   logic [IDX_W-1:0]  lat;
   logic              found;
   logic [SLIP_W-1:0] slip;
   logic [IDX_W-1:0]  start_idx;
   logic [SLOTS-1:0]  win_mask;

   always_comb begin
      data_cmd  = is_data_cmd(bus.cmd);
      write_cmd = is_write_cmd(bus.cmd);
      lat       = IDX_W'(cmd_latency(bus.cmd, CL, CLA, WR_OFFSET));
   end

   slot_first_fit #(
      .SLOTS    (SLOTS),
      .BURST    (BURST),
      .MAX_SLIP (MAX_SLIP)
   ) u_first_fit (
      .busy  (occ_q | bus.cong),
      .base  (lat),
      .found (found),
      .slip  (slip)
   );

   // The window is stored one slot lower because it lands after this edge's shift.
   always_comb begin
      start_idx    = lat + IDX_W'(slip) - IDX_W'(1);
      win_mask     = WIN0 << start_idx;
      occ_d        = occ_q >> 1;
      dir_d        = dir_q >> 1;
      alloc_ok_d   = 1'b0;
      alloc_rej_d  = 1'b0;
      alloc_slip_d = '0;
      mux_sel_d    = '0;
      if (data_cmd) begin
         if (found) begin
            occ_d        = occ_d | win_mask;
            dir_d        = write_cmd ? (dir_d | win_mask) : (dir_d & ~win_mask);
            alloc_ok_d   = 1'b1;
            alloc_slip_d = slip;
            mux_sel_d    = BIT0 << start_idx;
         end else begin
            alloc_rej_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q        <= '0;
         dir_q        <= '0;
         alloc_ok_q   <= 1'b0;
         alloc_rej_q  <= 1'b0;
         alloc_slip_q <= '0;
         mux_sel_q    <= '0;
      end else begin
         occ_q        <= occ_d;
         dir_q        <= dir_d;
         alloc_ok_q   <= alloc_ok_d;
         alloc_rej_q  <= alloc_rej_d;
         alloc_slip_q <= alloc_slip_d;
         mux_sel_q    <= mux_sel_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && data_cmd && found) begin
         a_no_overlap: assert (((occ_q >> 1) & win_mask) == '0);
      end
   end

   // dir is only ever set inside an occupied window, so dir_q[0] already implies occ_q[0].
   assign bus.alloc_ok   = alloc_ok_q;
   assign bus.alloc_rej  = alloc_rej_q;
   assign bus.alloc_slip = alloc_slip_q;
   assign bus.mux_sel    = mux_sel_q;
   assign bus.dq_active  = occ_q[0];
   assign bus.dq_write   = dir_q[0];
endmodule

// File: tb/tb_data_slot_alloc.sv
// Bench for data_slot_alloc: absolute-cycle bus reservation model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_data_slot_alloc;
   localparam int CL = 4, CLA = 6, WR_OFFSET = 2, SLOTS = 16, BURST = 2, MAX_SLIP = 4;
   localparam int NCYC = 1024;
   localparam logic [3:0] C_NOP = 4'b0000, C_WR = 4'b0111, C_WRA = 4'b0101,
                          C_RD = 4'b0100, C_RDA = 4'b1100;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_slot_alloc_if #(.SLOTS(SLOTS), .MAX_SLIP(MAX_SLIP)) bus ();

   data_slot_alloc #(
      .CL(CL), .CLA(CLA), .WR_OFFSET(WR_OFFSET),
      .SLOTS(SLOTS), .BURST(BURST), .MAX_SLIP(MAX_SLIP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Model: which absolute cycles the bus is booked for, and whether for a write.
   bit busy_m [NCYC];
   bit wr_m   [NCYC];
   bit model_on = 1'b0;
   logic        exp_ok, exp_rej;
   int          exp_slip;
   logic [15:0] exp_mux;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
      end
   endtask

   function automatic int nominal_lat(input logic [3:0] c);
      if (c == C_RD)  return CL;
      if (c == C_RDA) return CLA;
      if (c == C_WR)  return CL - WR_OFFSET;
      if (c == C_WRA) return CLA - WR_OFFSET;
      return 0;
   endfunction

   task automatic model_cmd(input logic [3:0] c, input logic [15:0] g);
      int l;
      bit ok_win;
      l = nominal_lat(c);
      if (l == 0) return;
      for (int s = 0; s <= MAX_SLIP; s++) begin
         ok_win = 1'b1;
         for (int k = 0; k < BURST; k++)
            if (busy_m[cyc + l + s + k] || g[l + s + k]) ok_win = 1'b0;
         if (ok_win) begin
            for (int k = 0; k < BURST; k++) begin
               busy_m[cyc + l + s + k] = 1'b1;
               wr_m[cyc + l + s + k]   = (c == C_WR) || (c == C_WRA);
            end
            exp_ok   = 1'b1;
            exp_slip = s;
            exp_mux[l + s - 1] = 1'b1;
            return;
         end
      end
      exp_rej = 1'b1;
   endtask

   // Compare process: check this cycle's outputs, then absorb this cycle's inputs.
   initial begin
      forever begin
         @(negedge clk);
         if (model_on) begin
            chk("alloc_ok",   32'(bus.alloc_ok),   32'(exp_ok));
            chk("alloc_rej",  32'(bus.alloc_rej),  32'(exp_rej));
            chk("alloc_slip", 32'(bus.alloc_slip), 32'(exp_slip));
            chk("mux_sel",    32'(bus.mux_sel),    32'(exp_mux));
            chk("dq_active",  32'(bus.dq_active),  32'(busy_m[cyc]));
            chk("dq_write",   32'(bus.dq_write),   32'(busy_m[cyc] & wr_m[cyc]));
         end
         exp_ok = 1'b0; exp_rej = 1'b0; exp_slip = 0; exp_mux = '0;
         if (rst) begin
            model_on = 1'b1;
            for (int i = cyc + 1; i < NCYC; i++) begin
               busy_m[i] = 1'b0;
               wr_m[i]   = 1'b0;
            end
         end else if (model_on) begin
            model_cmd(bus.cmd, bus.cong);
         end
         cyc++;
      end
   end

   task automatic drive(input logic r, input logic [3:0] c, input logic [15:0] g);
      @(posedge clk);
      #1;
      rst = r; bus.cmd = c; bus.cong = g;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, C_NOP, 16'h0000);
   endtask

   initial begin
      rst = 1'b1; bus.cmd = C_NOP; bus.cong = '0;
      drive(1'b1, C_NOP, 16'h0000);
      drive(1'b1, C_NOP, 16'h0000);
      idle(20);
      @(negedge clk);
      chk("idle_dq_active", 32'(bus.dq_active), 32'd0);
      chk("idle_alloc_ok",  32'(bus.alloc_ok),  32'd0);

      // Single RD: grant next cycle, burst 4..5 cycles later.
      drive(1'b0, C_RD, 16'h0000);
      idle(1); @(negedge clk);
      chk("rd_ok",   32'(bus.alloc_ok),   32'd1);
      chk("rd_slip", 32'(bus.alloc_slip), 32'd0);
      chk("rd_mux",  32'(bus.mux_sel),    32'h0008);
      idle(3); @(negedge clk);
      chk("rd_dq_a0", 32'(bus.dq_active), 32'd1);
      chk("rd_dq_w0", 32'(bus.dq_write),  32'd0);
      idle(1); @(negedge clk);
      chk("rd_dq_a1", 32'(bus.dq_active), 32'd1);
      idle(1); @(negedge clk);
      chk("rd_dq_end", 32'(bus.dq_active), 32'd0);
      idle(4);

      // WR, RD, RDA back to back.
      drive(1'b0, C_WR, 16'h0000);
      drive(1'b0, C_RD, 16'h0000); @(negedge clk);
      chk("wr_mux", 32'(bus.mux_sel), 32'h0002);
      drive(1'b0, C_RDA, 16'h0000); @(negedge clk);
      chk("rd2_mux",  32'(bus.mux_sel),  32'h0008);
      chk("wr_dq_w0", 32'(bus.dq_write), 32'd1);
      idle(1); @(negedge clk);
      chk("rda_mux",  32'(bus.mux_sel),    32'h0020);
      chk("rda_slip", 32'(bus.alloc_slip), 32'd0);
      chk("wr_dq_w1", 32'(bus.dq_write),   32'd1);
      idle(2); @(negedge clk);
      chk("rd2_dq_a", 32'(bus.dq_active), 32'd1);
      chk("rd2_dq_w", 32'(bus.dq_write),  32'd0);
      idle(3); @(negedge clk);
      chk("rda_dq_a", 32'(bus.dq_active), 32'd1);
      idle(8);

      // RD, then RD with congestion on slots 4..5 -> slip 2.
      drive(1'b0, C_RD, 16'h0000);
      drive(1'b0, C_RD, 16'h0030);
      idle(1); @(negedge clk);
      chk("cong_ok",   32'(bus.alloc_ok),   32'd1);
      chk("cong_slip", 32'(bus.alloc_slip), 32'd2);
      chk("cong_mux",  32'(bus.mux_sel),    32'h0020);
      idle(2); @(negedge clk);
      chk("cong_dq_first", 32'(bus.dq_active), 32'd1);
      idle(2); @(negedge clk);
      chk("cong_dq_gap", 32'(bus.dq_active), 32'd0);
      idle(1); @(negedge clk);
      chk("cong_dq_s0", 32'(bus.dq_active), 32'd1);
      idle(1); @(negedge clk);
      chk("cong_dq_s1", 32'(bus.dq_active), 32'd1);
      idle(8);

      // Back-to-back RDs: slips 0,1,2,3,4, then reject.
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, C_RD, 16'h0000);
         if (k > 0) begin
            @(negedge clk);
            chk("fill_ok",   32'(bus.alloc_ok),   32'd1);
            chk("fill_slip", 32'(bus.alloc_slip), 32'(k - 1));
         end
      end
      idle(1); @(negedge clk);
      chk("fill_rej", 32'(bus.alloc_rej), 32'd1);
      chk("fill_ok0", 32'(bus.alloc_ok),  32'd0);
      idle(1); @(negedge clk);
      chk("fill_rej_pulse", 32'(bus.alloc_rej), 32'd0);
      idle(16);

      // Reset with two bursts pending.
      drive(1'b0, C_RD, 16'h0000);
      drive(1'b0, C_RD, 16'h0000);
      drive(1'b1, C_NOP, 16'h0000);
      idle(1); @(negedge clk);
      chk("rst_ok",   32'(bus.alloc_ok),  32'd0);
      chk("rst_dq_a", 32'(bus.dq_active), 32'd0);
      idle(1); @(negedge clk);
      chk("rst_dq_drop", 32'(bus.dq_active), 32'd0);
      idle(1);
      drive(1'b0, C_RD, 16'h0000);
      idle(1); @(negedge clk);
      chk("post_rst_ok",   32'(bus.alloc_ok),   32'd1);
      chk("post_rst_slip", 32'(bus.alloc_slip), 32'd0);
      idle(8);

      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete within time limit");
      $fatal(1);
   end
endmodule
